adc_channel_scheduler: RTL and testbench

ADC_CHANNEL_SCHEDULER -- requirements
Module: adc_channel_scheduler

---
 rtl/adc_sched_pkg.sv | 16 +
 rtl/adc_channel_scheduler_rr_arbiter.sv | 31 +++
 rtl/adc_channel_scheduler.sv | 155 +++++++++++++++
 tb/tb_adc_channel_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sched_pkg.sv
// Shared types and widths for the ADC channel scheduler.
// Holds the scheduler state encoding, the conversion data width and the
// width of the optional conversion timeout counter (ADC_SCHED_TIMEOUT_EN).
package adc_sched_pkg;

    localparam int DATA_W = 8;
    localparam int TMR_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_CONV  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/adc_channel_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the requester right after last_i has
// the highest priority, wrapping modulo NUM_REQ.
module rr_arbiter
    import adc_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [IDX_W-1:0]   win_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] idx;

    // Scan from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        win_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = IDX_W'((int'(last_i) + i) % NUM_REQ);
            if (req_i[idx]) begin
                win_o   = idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_channel_scheduler.sv
// ADC channel scheduler: arbitrates NUM_REQ requesters round-robin onto one
// shared ADC, runs one conversion at a time and returns the result through
// a valid/ready response port.
// Optional build macro ADC_SCHED_TIMEOUT_EN adds a CONV watchdog that aborts
// a conversion after CONV_TIMEOUT cycles and reports rsp_err=1.
module adc_channel_scheduler
    import adc_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CONV_TIMEOUT = 300
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       adc_start,
    output logic [$clog2(NUM_REQ)-1:0] adc_chan,
    input  logic                       adc_done,
    input  logic [DATA_W-1:0]          adc_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_err,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   chan_q, chan_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [IDX_W-1:0]   arb_win;
    logic               arb_vld;
    logic               tmo;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i   (req),
        .last_i  (last_q),
        .win_o   (arb_win),
        .valid_o (arb_vld)
    );

`ifdef ADC_SCHED_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(CONV_TIMEOUT - 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             err_q, err_d;

    // Timer holds zero outside CONV so every conversion starts counting from zero.
    always_comb begin
        tmr_d = '0;
        if (state_q == ST_CONV) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
    end

    assign tmo = (state_q == ST_CONV) && (tmr_q == TMO_LAST);

    // Error flag follows how CONV ended; a done in the expiry cycle still counts as success.
    always_comb begin
        err_d = err_q;
        if (state_q == ST_CONV) begin
            if (adc_done) begin
                err_d = 1'b0;
            end else if (tmo) begin
                err_d = 1'b1;
            end
        end
    end

    // Watchdog counter and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            err_q <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    // Without the watchdog the timeout parameter has no effect.
    logic unused_cfg;
    assign unused_cfg = ^{CONV_TIMEOUT, TMR_W};
    assign tmo        = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    // Next-state logic: arbitrate in IDLE, commit the winner in START, capture in CONV.
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        last_d  = last_q;
        data_d  = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    chan_d  = arb_win;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                last_d  = chan_q;
                state_d = ST_CONV;
            end
            ST_CONV: begin
                if (adc_done) begin
                    data_d  = adc_data;
                    state_d = ST_RESP;
                end else if (tmo) begin
                    data_d  = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            chan_q  <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    // Outputs are decoded from registered state only, so none depend on inputs combinationally.
    assign gnt       = (state_q == ST_START) ? (NUM_REQ'(1) << chan_q) : '0;
    assign adc_start = (state_q == ST_START);
    assign adc_chan  = chan_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = chan_q;
    assign rsp_data  = data_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Self-checking bench for adc_channel_scheduler (NUM_REQ=4, CONV_TIMEOUT=20).
module tb_adc_channel_scheduler;

    localparam int N  = 4;
    localparam int TO = 20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         adc_start;
    logic [1:0]   adc_chan;
    logic         adc_done;
    logic [7:0]   adc_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [7:0]   rsp_data;
    logic         rsp_err;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int mdl_last;

    typedef struct {
        logic [3:0] gnt;
        logic       start;
        logic [1:0] chan;
        int         lat;
        int         stray;
        int         unstable;
        logic [1:0] id;
        logic [7:0] data;
        logic       err;
        logic       idle;
    } obs_t;

    always #5 clk = ~clk;

    adc_channel_scheduler #(
        .NUM_REQ      (N),
        .CONV_TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .adc_start (adc_start),
        .adc_chan  (adc_chan),
        .adc_done  (adc_done),
        .adc_data  (adc_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    // Reference arbitration: first set request at (last+1), (last+2), ... mod N.
    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            if (r[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    // Drives one full request/convert/respond transaction and records what the DUT did.
    task automatic run_xact(input logic [3:0] rq, input int done_cyc, input logic [7:0] dat,
                            input int stall, input logic early, input logic [3:0] late,
                            output obs_t o);
        int j;
        o.stray = 0; o.unstable = 0; o.lat = -1;
        req = rq;
        @(negedge clk);
        o.gnt = gnt; o.start = adc_start; o.chan = adc_chan;
        req = (rq & ~gnt) | late;
        adc_done = early; adc_data = 8'hEE;
        j = 0;
        while (j < 100) begin
            @(negedge clk);
            j++;
            if (rsp_valid === 1'b1) break;
            if (gnt !== 4'b0 || adc_start !== 1'b0 || adc_chan !== o.chan || busy !== 1'b1) o.stray++;
            adc_done = (j == done_cyc);
            adc_data = (j == done_cyc) ? dat : 8'($urandom);
        end
        adc_done = 1'b0;
        if (rsp_valid === 1'b1) o.lat = j;
        o.id = rsp_id; o.data = rsp_data; o.err = rsp_err;
        for (int s = 0; s < stall; s++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_id !== o.id || rsp_data !== o.data || rsp_err !== o.err ||
                gnt !== 4'b0 || adc_start !== 1'b0) o.unstable++;
        end
        rsp_ready = 1'b1; adc_done = 1'b1; adc_data = 8'h11;
        @(negedge clk);
        rsp_ready = 1'b0; adc_done = 1'b0;
        o.idle = (busy === 1'b0 && rsp_valid === 1'b0 && gnt === 4'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        req = '0; rsp_ready = 1'b0; adc_done = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mdl_last = N - 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        req = '0; rsp_ready = 1'b0; adc_done = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        checks++; if (adc_start !== 1'b0) begin errors++; $display("FAIL reset_adc_start got %b want 0", adc_start); end
        checks++; if (adc_chan !== 2'd0) begin errors++; $display("FAIL reset_adc_chan got %0d want 0", adc_chan); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %h want 00", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        mdl_last = N - 1;
    endtask

    task automatic test_single();
        obs_t o;
        run_xact(4'b0100, 5, 8'h5A, 0, 1'b1, 4'b0000, o);
        checks++; if (o.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b want 0100", o.gnt); end
        checks++; if (o.start !== 1'b1) begin errors++; $display("FAIL single_adc_start got %b want 1", o.start); end
        checks++; if (o.chan !== 2'd2) begin errors++; $display("FAIL single_adc_chan got %0d want 2", o.chan); end
        checks++; if (o.lat !== 6) begin errors++; $display("FAIL single_latency got %0d want 6", o.lat); end
        checks++; if (o.id !== 2'd2) begin errors++; $display("FAIL single_rsp_id got %0d want 2", o.id); end
        checks++; if (o.data !== 8'h5A) begin errors++; $display("FAIL single_rsp_data got %h want 5a", o.data); end
        checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL single_rsp_err got %b want 0", o.err); end
        checks++; if (o.stray !== 0) begin errors++; $display("FAIL single_conv_outputs got %0d bad cycles want 0", o.stray); end
        checks++; if (o.idle !== 1'b1) begin errors++; $display("FAIL single_back_to_idle got %b want 1", o.idle); end
        mdl_last = 2;
    endtask

    task automatic test_round_robin();
        obs_t o;
        int order[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            logic [3:0] eg;
            eg = 4'(1) << order[k];
            run_xact(4'b1111, 1 + k, 8'(8'h30 + k), 0, 1'b0, 4'b0000, o);
            checks++; if (o.gnt !== eg) begin errors++; $display("FAIL rr_gnt[%0d] got %b want %b", k, o.gnt, eg); end
            checks++; if (o.id !== 2'(order[k]) || o.data !== 8'(8'h30 + k)) begin
                errors++; $display("FAIL rr_rsp[%0d] got id %0d data %h want id %0d data %h", k, o.id, o.data, order[k], 8'(8'h30 + k)); end
            checks++; if (o.stray !== 0 || o.idle !== 1'b1) begin
                errors++; $display("FAIL rr_pulse[%0d] got stray %0d idle %b want 0 1", k, o.stray, o.idle); end
            mdl_last = order[k];
        end
    endtask

    task automatic test_single_requester();
        obs_t o;
        for (int k = 0; k < 3; k++) begin
            run_xact(4'b1000, 1, 8'(k), 0, 1'b0, 4'b0000, o);
            checks++; if (o.gnt !== 4'b1000 || o.lat !== 2) begin
                errors++; $display("FAIL solo[%0d] got gnt %b lat %0d want 1000 2", k, o.gnt, o.lat); end
        end
        mdl_last = 3;
    endtask

    task automatic test_drop();
        obs_t o;
        apply_reset();
        run_xact(4'b0100, 2, 8'h33, 1, 1'b0, 4'b1000, o);
        checks++; if (o.gnt !== 4'b0100) begin errors++; $display("FAIL drop_first_gnt got %b want 0100", o.gnt); end
        run_xact(4'b0001, 2, 8'h44, 0, 1'b0, 4'b0000, o);
        checks++; if (o.gnt !== 4'b0001 || o.data !== 8'h44) begin
            errors++; $display("FAIL drop_forgotten got gnt %b data %h want 0001 44", o.gnt, o.data); end
        mdl_last = 0;
    endtask

    task automatic test_stall();
        obs_t o;
        run_xact(4'b0010, 3, 8'hC3, 10, 1'b0, 4'b1101, o);
        checks++; if (o.gnt !== 4'b0010) begin errors++; $display("FAIL stall_gnt got %b want 0010", o.gnt); end
        checks++; if (o.unstable !== 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles want 0", o.unstable); end
        checks++; if (o.id !== 2'd1 || o.data !== 8'hC3) begin
            errors++; $display("FAIL stall_rsp got id %0d data %h want 1 c3", o.id, o.data); end
        mdl_last = 1;
    endtask

    task automatic test_random();
        obs_t o;
        for (int k = 0; k < 12; k++) begin
            logic [3:0] rq, late, eg;
            logic [7:0] dat;
            int d, st, exp_w;
            rq    = 4'($urandom_range(1, 15));
            late  = 4'($urandom);
            dat   = 8'($urandom);
            d     = int'($urandom_range(1, 8));
            st    = int'($urandom_range(0, 3));
            exp_w = rr_pick(rq, mdl_last);
            eg    = 4'(1) << exp_w;
            run_xact(rq, d, dat, st, 1'($urandom), late, o);
            checks++; if (o.gnt !== eg || o.chan !== 2'(exp_w) || o.id !== 2'(exp_w)) begin
                errors++; $display("FAIL rand_arb[%0d] req %b got gnt %b chan %0d id %0d want gnt %b", k, rq, o.gnt, o.chan, o.id, eg); end
            checks++; if (o.data !== dat || o.err !== 1'b0 || o.lat !== d + 1) begin
                errors++; $display("FAIL rand_rsp[%0d] got data %h err %b lat %0d want %h 0 %0d", k, o.data, o.err, o.lat, dat, d + 1); end
            checks++; if (o.stray !== 0 || o.unstable !== 0 || o.idle !== 1'b1) begin
                errors++; $display("FAIL rand_ctrl[%0d] got stray %0d unstable %0d idle %b want 0 0 1", k, o.stray, o.unstable, o.idle); end
            mdl_last = exp_w;
        end
    endtask

    task automatic test_reset_mid_conv();
        obs_t o;
        int bad;
        apply_reset();
        req = 4'b0010;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || adc_chan !== 2'd0 || rsp_valid !== 1'b0 || gnt !== 4'b0 || adc_start !== 1'b0) begin
            errors++; $display("FAIL midconv_reset got busy %b chan %0d valid %b gnt %b start %b want all 0", busy, adc_chan, rsp_valid, gnt, adc_start); end
        @(negedge clk);
        rst_n = 1'b1;
        mdl_last = N - 1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            adc_done = (k == 1); adc_data = 8'h77;
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0 || rsp_data !== 8'h00) bad++;
        end
        adc_done = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL midconv_quiet got %0d bad cycles want 0", bad); end
        run_xact(4'b1111, 2, 8'h81, 0, 1'b0, 4'b0000, o);
        checks++; if (o.gnt !== 4'b0001 || o.data !== 8'h81) begin
            errors++; $display("FAIL midconv_next got gnt %b data %h want 0001 81", o.gnt, o.data); end
        mdl_last = 0;
    endtask

`ifdef ADC_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        run_xact(4'b0001, 0, 8'hFF, 2, 1'b0, 4'b0000, o);
        checks++; if (o.lat !== TO + 1) begin errors++; $display("FAIL tmo_latency got %0d want %0d", o.lat, TO + 1); end
        checks++; if (o.err !== 1'b1 || o.data !== 8'h00) begin
            errors++; $display("FAIL tmo_rsp got err %b data %h want 1 00", o.err, o.data); end
        checks++; if (o.unstable !== 0) begin errors++; $display("FAIL tmo_hold got %0d bad cycles want 0", o.unstable); end
        run_xact(4'b0001, TO, 8'hA5, 0, 1'b0, 4'b0000, o);
        checks++; if (o.lat !== TO + 1 || o.err !== 1'b0 || o.data !== 8'hA5) begin
            errors++; $display("FAIL tmo_done_wins got lat %0d err %b data %h want %0d 0 a5", o.lat, o.err, o.data, TO + 1); end
    endtask
`endif

    initial begin
        rst_n = 1'b1; req = '0; adc_done = 1'b0; adc_data = '0; rsp_ready = 1'b0;
        mdl_last = N - 1;
        test_reset();
        test_single();
        test_round_robin();
        test_single_requester();
        test_drop();
        test_stall();
        test_random();
        test_reset_mid_conv();
`ifdef ADC_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "simulation time limit");
    end

endmodule
